// File: rtl/mem_stage_pkg.sv
// Shared widths, load one-hot bit positions and stall encoding for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned EX_TO_MEM_WD = 76;
  localparam int unsigned LOAD_WD      = 5;
  localparam int unsigned HI_LO_WD     = 66;
  localparam int unsigned MEM_TO_WB_WD = 70;
  localparam int unsigned MEM_TO_RF_WD = 38;
  localparam int unsigned STALL_WD     = 6;

  // Load one-hot: {lb, lbu, lh, lhu, lw}
  localparam int unsigned LD_LB  = 4;
  localparam int unsigned LD_LBU = 3;
  localparam int unsigned LD_LH  = 2;
  localparam int unsigned LD_LHU = 1;
  localparam int unsigned LD_LW  = 0;

  localparam int unsigned STALL_MEM = 3;
  localparam int unsigned STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [0:0] {HoldLive, HoldHeld} hold_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load lane selection and sign/zero extension for lb/lbu/lh/lhu/lw.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]        rdata_eff,
  input  logic [1:0]         addr,
  input  logic [LOAD_WD-1:0] load,
  output logic [31:0]        result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_eff[7:0];
    unique case (addr)
      2'd0: byte_sel = rdata_eff[7:0];
      2'd1: byte_sel = rdata_eff[15:8];
      2'd2: byte_sel = rdata_eff[23:16];
      2'd3: byte_sel = rdata_eff[31:24];
      default: byte_sel = rdata_eff[7:0];
    endcase
    half_sel = addr[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    // lw and the (unused) empty one-hot both pass the word through.
    result = rdata_eff;
    if (load[LD_LB])       result = {{24{byte_sel[7]}}, byte_sel};
    else if (load[LD_LBU]) result = {24'd0, byte_sel};
    else if (load[LD_LH])  result = {{16{half_sel[15]}}, half_sel};
    else if (load[LD_LHU]) result = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, load read-data hold buffer, load alignment
// and packing of the WB, forwarding and HI/LO buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [LOAD_WD-1:0]      ex_load_bus,
  input  logic [HI_LO_WD-1:0]     ex_hi_lo_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
  output logic [HI_LO_WD-1:0]     mem_hi_lo_bus,
  output logic                    mem_is_load
);

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_q;
  logic [LOAD_WD-1:0]      load_q;
  logic [HI_LO_WD-1:0]     hi_lo_q;
  hold_state_e             state_q;
  logic [31:0]             hold_data_q;

  logic mem_stop, wb_stop, reg_hold, is_load, hold_valid;
  assign mem_stop   = (stall[STALL_MEM] == STOP);
  assign wb_stop    = (stall[STALL_WB] == STOP);
  assign reg_hold   = mem_stop && wb_stop;
  assign is_load    = |load_q;
  assign hold_valid = (state_q == HoldHeld);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_q <= '0;
      load_q      <= '0;
      hi_lo_q     <= '0;
    end else if (mem_stop && !wb_stop) begin
      ex_to_mem_q <= '0;
      load_q      <= '0;
      hi_lo_q     <= '0;
    end else if (!mem_stop) begin
      ex_to_mem_q <= ex_to_mem_bus;
      load_q      <= ex_load_bus;
      hi_lo_q     <= ex_hi_lo_bus;
    end
  end

  // SRAM data is only valid in the first MEM cycle; capture it if the stage stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HoldLive;
      hold_data_q <= '0;
    end else begin
      unique case (state_q)
        HoldLive: begin
          if (reg_hold && is_load) begin
            state_q     <= HoldHeld;
            hold_data_q <= data_sram_rdata;
          end
        end
        HoldHeld: begin
          if (!reg_hold) state_q <= HoldLive;
        end
        default: state_q <= HoldLive;
      endcase
    end
  end

  logic [31:0] pc, ex_result, rdata_eff, load_result, rf_wdata;
  logic        sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;

  assign pc         = ex_to_mem_q[75:44];
  assign sel_rf_res = ex_to_mem_q[38];
  assign rf_we      = ex_to_mem_q[37];
  assign rf_waddr   = ex_to_mem_q[36:32];
  assign ex_result  = ex_to_mem_q[31:0];
  assign rdata_eff  = hold_valid ? hold_data_q : data_sram_rdata;

  mem_load_align u_load_align (
    .rdata_eff (rdata_eff),
    .addr      (ex_result[1:0]),
    .load      (load_q),
    .result    (load_result)
  );

  assign rf_wdata      = (sel_rf_res && is_load) ? load_result : ex_result;
  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};
  assign mem_hi_lo_bus = hi_lo_q;
  assign mem_is_load   = is_load;

  logic unused_bits;
  assign unused_bits = ^{ex_to_mem_q[43:39], stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for lane/extension, sequences for stalls and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_WD-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [LOAD_WD-1:0]      ex_load_bus;
  logic [HI_LO_WD-1:0]     ex_hi_lo_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;
  logic [HI_LO_WD-1:0]     mem_hi_lo_bus;
  logic                    mem_is_load;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_load_bus     (ex_load_bus),
    .ex_hi_lo_bus    (ex_hi_lo_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_rf_bus   (mem_to_rf_bus),
    .mem_hi_lo_bus   (mem_hi_lo_bus),
    .mem_is_load     (mem_is_load)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] L_LB  = 5'b10000;
  localparam logic [4:0] L_LBU = 5'b01000;
  localparam logic [4:0] L_LH  = 5'b00100;
  localparam logic [4:0] L_LHU = 5'b00010;
  localparam logic [4:0] L_LW  = 5'b00001;
  localparam logic [4:0] L_NO  = 5'b00000;
  localparam logic [5:0] ST_HOLD   = 6'b011111;
  localparam logic [5:0] ST_BUBBLE = 6'b001111;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [4:0]  load;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic        ram_en;
    logic [3:0]  wen;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_load;
  } vec_t;

  vec_t vecs[12];

  task automatic drive_ex(input logic [31:0] pc, input logic [31:0] result,
                          input logic [4:0] load, input logic sel, input logic we,
                          input logic [4:0] waddr, input logic ram_en, input logic [3:0] wen);
    ex_to_mem_bus = {pc, ram_en, wen, sel, we, waddr, result};
    ex_load_bus   = load;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00400000, 32'h00000100, L_LW,  1'b1, 1'b1, 5'd8,  1'b1, 4'h0,
                 32'h8899AABB, 32'h8899AABB, 1'b1};
    vecs[1]  = '{32'h00400004, 32'h00000201, L_LB,  1'b1, 1'b1, 5'd9,  1'b1, 4'h0,
                 32'h12348067, 32'hFFFFFF80, 1'b1};
    vecs[2]  = '{32'h00400008, 32'h00000201, L_LBU, 1'b1, 1'b1, 5'd10, 1'b1, 4'h0,
                 32'h12348067, 32'h00000080, 1'b1};
    vecs[3]  = '{32'h0040000C, 32'h00000202, L_LH,  1'b1, 1'b1, 5'd11, 1'b1, 4'h0,
                 32'h80015555, 32'hFFFF8001, 1'b1};
    vecs[4]  = '{32'h00400010, 32'h00000202, L_LHU, 1'b1, 1'b1, 5'd12, 1'b1, 4'h0,
                 32'h80015555, 32'h00008001, 1'b1};
    vecs[5]  = '{32'h00400014, 32'h00000203, L_LB,  1'b1, 1'b1, 5'd13, 1'b1, 4'h0,
                 32'h7F000000, 32'h0000007F, 1'b1};
    vecs[6]  = '{32'h00400018, 32'h00000203, L_LH,  1'b1, 1'b1, 5'd14, 1'b1, 4'h0,
                 32'h80011234, 32'hFFFF8001, 1'b1};
    vecs[7]  = '{32'h0040001C, 32'h00000200, L_LH,  1'b1, 1'b1, 5'd15, 1'b1, 4'h0,
                 32'h12347FFF, 32'h00007FFF, 1'b1};
    vecs[8]  = '{32'h00400020, 32'h00000200, L_LBU, 1'b1, 1'b1, 5'd16, 1'b1, 4'h0,
                 32'h000000FF, 32'h000000FF, 1'b1};
    vecs[9]  = '{32'h00400024, 32'h00000005, L_NO,  1'b0, 1'b1, 5'd17, 1'b0, 4'h0,
                 32'hFFFFFFFF, 32'h00000005, 1'b0};
    vecs[10] = '{32'h00400028, 32'h00001234, L_NO,  1'b1, 1'b1, 5'd18, 1'b0, 4'h0,
                 32'hFFFFFFFF, 32'h00001234, 1'b0};
    vecs[11] = '{32'h0040002C, 32'h00000300, L_NO,  1'b0, 1'b0, 5'd0,  1'b1, 4'hF,
                 32'h11111111, 32'h00000300, 1'b0};

    // Reset with busy inputs: all outputs must be zero.
    rst = 1'b1;
    stall = '0;
    ex_hi_lo_bus = {2'b11, 32'hAAAA5555, 32'h5555AAAA};
    data_sram_rdata = 32'hFFFFFFFF;
    drive_ex(32'h12345678, 32'h9ABCDEF0, L_LW, 1'b1, 1'b1, 5'd31, 1'b1, 4'hF);
    tick();
    tick();
    check("reset wb", mem_to_wb_bus, '0);
    check("reset rf", mem_to_rf_bus, '0);
    check("reset hilo", mem_hi_lo_bus, '0);
    check("reset is_load", mem_is_load, 1'b0);
    rst = 1'b0;
    ex_hi_lo_bus = '0;

    for (int i = 0; i < 12; i++) begin
      drive_ex(vecs[i].pc, vecs[i].result, vecs[i].load, vecs[i].sel, vecs[i].we,
               vecs[i].waddr, vecs[i].ram_en, vecs[i].wen);
      tick();
      data_sram_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d wb", i), mem_to_wb_bus,
            {vecs[i].pc, vecs[i].we, vecs[i].waddr, vecs[i].exp_wdata});
      check($sformatf("vec%0d rf", i), mem_to_rf_bus,
            {vecs[i].we, vecs[i].waddr, vecs[i].exp_wdata});
      check($sformatf("vec%0d is_load", i), mem_is_load, vecs[i].exp_load);
    end

    // lw stalled in MEM while SRAM data changes: held value must persist.
    drive_ex(32'h00000500, 32'h00000400, L_LW, 1'b1, 1'b1, 5'd3, 1'b1, 4'h0);
    tick();
    data_sram_rdata = 32'h11223344;
    stall = ST_HOLD;
    drive_ex(32'h00000504, 32'h00000099, L_NO, 1'b0, 1'b1, 5'd4, 1'b0, 4'h0);
    #1;
    check("hold first", mem_to_rf_bus, {1'b1, 5'd3, 32'h11223344});
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      check($sformatf("hold cyc%0d", c), mem_to_wb_bus,
            {32'h00000500, 1'b1, 5'd3, 32'h11223344});
      check($sformatf("hold is_load%0d", c), mem_is_load, 1'b1);
    end
    stall = '0;
    tick();
    check("after release", mem_to_wb_bus, {32'h00000504, 1'b1, 5'd4, 32'h00000099});
    drive_ex(32'h00000508, 32'h00000404, L_LW, 1'b1, 1'b1, 5'd5, 1'b1, 4'h0);
    tick();
    data_sram_rdata = 32'h55667788;
    #1;
    check("live after hold", mem_to_rf_bus, {1'b1, 5'd5, 32'h55667788});

    // mult HI/LO passthrough, then a bubble, then the addu after release.
    ex_hi_lo_bus = {2'b11, 32'h00000001, 32'h00000002};
    drive_ex(32'h00000700, 32'h00000000, L_NO, 1'b0, 1'b0, 5'd0, 1'b0, 4'h0);
    tick();
    check("mult hilo", mem_hi_lo_bus, {2'b11, 32'h00000001, 32'h00000002});
    check("mult rf_we", mem_to_rf_bus[37], 1'b0);
    ex_hi_lo_bus = '0;
    stall = ST_BUBBLE;
    drive_ex(32'h00000704, 32'h00000005, L_NO, 1'b0, 1'b1, 5'd9, 1'b0, 4'h0);
    tick();
    check("bubble wb", mem_to_wb_bus, '0);
    check("bubble hilo", mem_hi_lo_bus, '0);
    check("bubble is_load", mem_is_load, 1'b0);
    stall = '0;
    tick();
    check("addu after bubble", mem_to_wb_bus, {32'h00000704, 1'b1, 5'd9, 32'h00000005});

    // Bubble while HELD must drop the held word.
    drive_ex(32'h00000900, 32'h00000600, L_LW, 1'b1, 1'b1, 5'd6, 1'b1, 4'h0);
    tick();
    data_sram_rdata = 32'h01020304;
    stall = ST_HOLD;
    tick();
    stall = ST_BUBBLE;
    tick();
    check("bubble from held", mem_to_wb_bus, '0);
    stall = '0;
    drive_ex(32'h00000904, 32'h00000604, L_LW, 1'b1, 1'b1, 5'd7, 1'b1, 4'h0);
    tick();
    data_sram_rdata = 32'h0A0B0C0D;
    #1;
    check("live after bubble", mem_to_rf_bus, {1'b1, 5'd7, 32'h0A0B0C0D});

    // Reset while HELD.
    drive_ex(32'h00000800, 32'h00000400, L_LW, 1'b1, 1'b1, 5'd2, 1'b1, 4'h0);
    tick();
    data_sram_rdata = 32'hA5A5A5A5;
    stall = ST_HOLD;
    tick();
    rst = 1'b1;
    stall = '0;
    tick();
    check("rst held wb", mem_to_wb_bus, '0);
    check("rst held rf", mem_to_rf_bus, '0);
    check("rst held hilo", mem_hi_lo_bus, '0);
    check("rst held is_load", mem_is_load, 1'b0);
    rst = 1'b0;
    drive_ex(32'h00000804, 32'h00000404, L_LW, 1'b1, 1'b1, 5'd2, 1'b1, 4'h0);
    tick();
    data_sram_rdata = 32'hCAFEF00D;
    #1;
    check("first lw after rst", mem_to_wb_bus, {32'h00000804, 1'b1, 5'd2, 32'hCAFEF00D});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of EX in the 5-stage MIPS core.
- Registers the EX→MEM bus and takes synchronous data-SRAM read data, which returns one cycle after EX issues the address.
- Performs load byte/halfword extraction and sign/zero extension.
- Drives the MEM→WB bus and the MEM forwarding bus to ID, and pipes HI/LO write requests through to WB.
- Includes a read-data hold buffer so load data survives downstream stalls.

Parameters:
- EX_TO_MEM_WD, 76, width of the EX→MEM bus: {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- LOAD_WD, 5, load-type one-hot: {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw}
- HI_LO_WD, 66, HI/LO write bus: {hi_we, lo_we, hi_wdata[31:0], lo_wdata[31:0]}
- MEM_TO_WB_WD, 70, MEM→WB bus: {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- STALL_WD, 6, stall vector width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  STALL_WD  stall vector; bit3 = MEM register, bit4 = WB register
- ex_to_mem_bus  in  EX_TO_MEM_WD  EX results
- ex_load_bus  in  LOAD_WD  load type of the instruction in EX
- ex_hi_lo_bus  in  HI_LO_WD  HI/LO write request from EX
- data_sram_rdata  in  32  synchronous SRAM read data
- mem_to_wb_bus  out  MEM_TO_WB_WD  to WB
- mem_to_rf_bus  out  38  {rf_we, rf_waddr, rf_wdata}, forwarding to ID
- mem_hi_lo_bus  out  HI_LO_WD  HI/LO request to WB
- mem_is_load  out  1  a load instruction is in MEM, for load-use stall detection

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset clears all pipeline registers, hold_valid and hold_data. Every output is then 0.
- Pipeline register update, evaluated at each posedge in this priority:
  - rst: clear.
  - stall[3]=Stop and stall[4]=NoStop: load a bubble (all zeros).
  - stall[3]=NoStop: load ex_to_mem_bus, ex_load_bus and ex_hi_lo_bus.
  - Otherwise: hold.
- Read timing:
  - The SRAM samples its address at the end of the instruction's EX cycle.
  - data_sram_rdata is valid only in the first cycle the instruction sits in MEM. It is not guaranteed afterwards.
- Hold buffer, a two-state FSM:
  - LIVE → HELD: at a posedge where the register holds (stall[3]=Stop), a load is present and hold_valid=0. Action: hold_data←data_sram_rdata, hold_valid←1.
  - HELD → LIVE: whenever the register loads a new instruction or a bubble. Action: hold_valid←0.
  - Effective read word: rdata_eff = hold_valid ? hold_data : data_sram_rdata.
- Lane select uses addr[1:0] = ex_result[1:0]:
  - Byte lane k = rdata_eff[8k+7:8k].
  - Halfword: addr[1]=0 → rdata_eff[15:0]; addr[1]=1 → rdata_eff[31:16]; addr[0] is ignored.
  - No alignment exceptions are raised.
- Extension:
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw passes rdata_eff unmodified.
- rf_wdata = (sel_rf_res && any load bit) ? load result : ex_result.
- sel_rf_res=1 with a zero load one-hot (illegal combination) → ex_result.
- Outputs mem_to_wb_bus, mem_to_rf_bus and mem_hi_lo_bus are combinational from the registered fields and rdata_eff. Latency is 1 cycle from EX.
- mem_is_load = |load_r.
- A store in MEM: rf_we=0 (already encoded by EX) and the buffer is not engaged.
- Bubble:
  - rf_we=0, hi_we=0, lo_we=0, pc=0.
  - A bubble entering while hold_valid=1 clears hold_valid.
- Reset during HELD returns the FSM to LIVE on that edge.

Decomposition:
- Shared defines.vh holds:
  - EX_TO_MEM_WD, MEM_TO_WB_WD and HI_LO_WD widths.
  - LoadBus widened to 5, with bit-index constants LD_LB..LD_LW.
  - Stop/NoStop.
- One combinational sub-module, mem_load_align (inputs: rdata_eff, addr[1:0], load one-hot; output: 32-bit result), unit-testable on its own.
- Register, FSM and bus packing stay in mem_stage.

Test Plan:
- lw, addr 0x100, rdata 0x8899AABB, no stall → next cycle mem_to_wb rf_wdata=0x8899AABB, rf_we=1, mem_is_load=1.
- lb at addr low bits 01, rdata 0x12348067 → 0xFFFFFF80; lbu same → 0x00000080; lh at addr 10, rdata 0x8001xxxx → 0xFFFF8001; lhu → 0x00008001.
- lw in MEM with stall[3]=stall[4]=Stop for 3 cycles, rdata changes to 0xDEADBEEF after the first cycle → rf_wdata stays at the original value throughout; hold_valid clears when the stall releases.
- stall[3]=Stop, stall[4]=NoStop → next cycle mem_to_wb_bus=0 and mem_hi_lo_bus=0; an addu result 0x5 then appears the cycle after the release.
- EX sends mult with hi_we=lo_we=1, hi=0x1, lo=0x2 → mem_hi_lo_bus is identical one cycle later; a sw in MEM → rf_we=0 and mem_is_load=0.
- rst asserted while in HELD → next cycle all outputs are 0 and hold_valid=0; the first lw after reset returns live rdata.
